// File: rtl/eq_gain_sched_if.sv
// Coefficient-RAM write bus between eq_gain_sched and the double-buffered
// coefficient RAM, plus the active-bank select read by the EQ datapath.
interface eq_gain_sched_if #(
  parameter int CHAN_BITS = 10,
  parameter int GAIN_BITS = 16
);
  logic                 coef_we;
  logic                 coef_wbank;
  logic [CHAN_BITS-1:0] coef_addr;
  logic [GAIN_BITS-1:0] coef_data;
  logic                 coef_bank;

  modport master (
    output coef_we,
    output coef_wbank,
    output coef_addr,
    output coef_data,
    output coef_bank
  );

  modport slave (
    input coef_we,
    input coef_wbank,
    input coef_addr,
    input coef_data,
    input coef_bank
  );
endinterface

// File: rtl/eq_gain_sched.sv
// EQ gain scheduler: software gain commands -> shadow-bank writes, bank swap on sync, replay.
// Optional status counters are built when EQ_GAIN_SCHED_STATUS_EN is defined.
module eq_gain_sched #(
  parameter int CHAN_BITS  = 10,
  parameter int GAIN_BITS  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] cfg_word,
  input  logic        sync_in,
  output logic        busy,
  output logic [31:0] status_word,
  eq_gain_sched_if.master coef
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CMD_BITS = 1 + CHAN_BITS + GAIN_BITS;
  localparam logic [PTR_BITS:0] FULL_LVL = FIFO_DEPTH[PTR_BITS:0];

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR_A = 3'd1,
    ST_ARM  = 3'd2,
    ST_SWAP = 3'd3,
    ST_WR_B = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 init_q, init_d;
  logic                 last_tog_q, last_tog_d;
  logic [31:0]          prev_word_q, prev_word_d;
  logic [CMD_BITS-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [CMD_BITS-1:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PTR_BITS:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS:0]    rd_ptr_q, rd_ptr_d;
  logic [CMD_BITS-1:0]  cur_q, cur_d;
  logic [CHAN_BITS-1:0] cnt_q, cnt_d;
  logic                 bank_q, bank_d;
  logic                 we_q, we_d;
  logic [CHAN_BITS-1:0] addr_q, addr_d;
  logic [GAIN_BITS-1:0] data_q, data_d;

  logic                 cmd_valid;
  logic                 push;
  logic                 pop;
  logic [PTR_BITS:0]    fifo_level;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 cur_bcast;
  logic [CHAN_BITS-1:0] cur_chan;
  logic [GAIN_BITS-1:0] cur_gain;
  logic [CHAN_BITS-1:0] wr_addr;
  logic                 last_write;

  // A command must be stable for two cycles and carry a new toggle value.
  assign cmd_valid  = !init_q && (cfg_word == prev_word_q) && (cfg_word[31] != last_tog_q);
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == FULL_LVL);
  assign push       = cmd_valid && !fifo_full;

  assign cur_bcast  = cur_q[CMD_BITS-1];
  assign cur_chan   = cur_q[GAIN_BITS +: CHAN_BITS];
  assign cur_gain   = cur_q[GAIN_BITS-1:0];
  assign wr_addr    = cur_bcast ? cnt_q : cur_chan;
  assign last_write = !cur_bcast || (cnt_q == {CHAN_BITS{1'b1}});

  always_comb begin
    init_d      = 1'b0;
    prev_word_d = cfg_word;
    last_tog_d  = last_tog_q;
    if (init_q || cmd_valid) begin
      last_tog_d = cfg_word[31];
    end

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q[PTR_BITS-1:0]] = {cfg_word[30], cfg_word[20 +: CHAN_BITS],
                                            cfg_word[GAIN_BITS-1:0]};
      wr_ptr_d = wr_ptr_q + {{PTR_BITS{1'b0}}, 1'b1};
    end
    rd_ptr_d = rd_ptr_q + {{PTR_BITS{1'b0}}, pop};
  end

  // Outputs are registered, so each write appears one cycle after its FSM state.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = fifo_mem_q[rd_ptr_q[PTR_BITS-1:0]];
          cnt_d   = '0;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A, ST_WR_B: begin
        we_d   = 1'b1;
        addr_d = wr_addr;
        data_d = cur_gain;
        if (last_write) begin
          cnt_d   = '0;
          state_d = (state_q == ST_WR_A) ? ST_ARM : ST_IDLE;
        end else begin
          cnt_d = cnt_q + {{(CHAN_BITS-1){1'b0}}, 1'b1};
        end
      end
      ST_ARM: begin
        if (sync_in) begin
          bank_d  = ~bank_q;
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        cnt_d   = '0;
        state_d = ST_WR_B;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q     <= ST_IDLE;
      init_q      <= 1'b1;
      last_tog_q  <= 1'b0;
      prev_word_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cur_q       <= '0;
      cnt_q       <= '0;
      bank_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      last_tog_q  <= last_tog_d;
      prev_word_q <= prev_word_d;
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign coef.coef_we    = we_q;
  assign coef.coef_wbank = ~bank_q;
  assign coef.coef_addr  = addr_q;
  assign coef.coef_data  = data_q;
  assign coef.coef_bank  = bank_q;
  assign busy            = (state_q != ST_IDLE) || !fifo_empty;

`ifdef EQ_GAIN_SCHED_STATUS_EN
  logic [7:0]  ovf_cnt_q, ovf_cnt_d;
  logic [15:0] swap_cnt_q, swap_cnt_d;
  logic [3:0]  fifo_level_w;

  always_comb begin
    ovf_cnt_d  = ovf_cnt_q;
    swap_cnt_d = swap_cnt_q;
    if (cmd_valid && fifo_full && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
    if ((state_q == ST_ARM) && sync_in) begin
      swap_cnt_d = swap_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      ovf_cnt_q  <= '0;
      swap_cnt_q <= '0;
    end else begin
      ovf_cnt_q  <= ovf_cnt_d;
      swap_cnt_q <= swap_cnt_d;
    end
  end

  assign fifo_level_w = 4'(fifo_level);
  assign status_word  = {busy, state_q, fifo_level_w, ovf_cnt_q, swap_cnt_q};
`else
  assign status_word = 32'd0;
`endif

endmodule
